// File: rtl/axi_mem_slave_if.sv
// AXI3 bus bundle between an HP-port style master and axi_mem_slave.
// The slave modport is the memory side; the master modport is the initiator side.
interface axi_mem_slave_if #(
  parameter int AXI_ID_WIDTH   = 6,
  parameter int AXI_LEN_WIDTH  = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64
);
  logic [AXI_ID_WIDTH-1:0]     axi_awid;
  logic [AXI_ADDR_WIDTH-1:0]   axi_awaddr;
  logic [AXI_LEN_WIDTH-1:0]    axi_awlen;
  logic [2:0]                  axi_awsize;
  logic [1:0]                  axi_awburst;
  logic [1:0]                  axi_awlock;
  logic [3:0]                  axi_awcache;
  logic [2:0]                  axi_awprot;
  logic [3:0]                  axi_awqos;
  logic                        axi_awvalid;
  logic                        axi_awready;

  logic [AXI_ID_WIDTH-1:0]     axi_wid;
  logic [AXI_DATA_WIDTH-1:0]   axi_wdata;
  logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb;
  logic                        axi_wlast;
  logic                        axi_wvalid;
  logic                        axi_wready;

  logic [AXI_ID_WIDTH-1:0]     axi_bid;
  logic [1:0]                  axi_bresp;
  logic                        axi_bvalid;
  logic                        axi_bready;

  logic [AXI_ID_WIDTH-1:0]     axi_arid;
  logic [AXI_ADDR_WIDTH-1:0]   axi_araddr;
  logic [AXI_LEN_WIDTH-1:0]    axi_arlen;
  logic [2:0]                  axi_arsize;
  logic [1:0]                  axi_arburst;
  logic [1:0]                  axi_arlock;
  logic [3:0]                  axi_arcache;
  logic [2:0]                  axi_arprot;
  logic [3:0]                  axi_arqos;
  logic                        axi_arvalid;
  logic                        axi_arready;

  logic [AXI_ID_WIDTH-1:0]     axi_rid;
  logic [AXI_DATA_WIDTH-1:0]   axi_rdata;
  logic [1:0]                  axi_rresp;
  logic                        axi_rlast;
  logic                        axi_rvalid;
  logic                        axi_rready;

  modport slave (
    input  axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awlock,
           axi_awcache, axi_awprot, axi_awqos, axi_awvalid,
    output axi_awready,
    input  axi_wid, axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
    output axi_wready,
    output axi_bid, axi_bresp, axi_bvalid,
    input  axi_bready,
    input  axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arlock,
           axi_arcache, axi_arprot, axi_arqos, axi_arvalid,
    output axi_arready,
    output axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
    input  axi_rready
  );

  modport master (
    output axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awlock,
           axi_awcache, axi_awprot, axi_awqos, axi_awvalid,
    input  axi_awready,
    output axi_wid, axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
    input  axi_wready,
    input  axi_bid, axi_bresp, axi_bvalid,
    output axi_bready,
    output axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arlock,
           axi_arcache, axi_arprot, axi_arqos, axi_arvalid,
    input  axi_arready,
    input  axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
    output axi_rready
  );
endinterface

// File: rtl/axi_mem_slave.sv
// AXI3 memory slave: independent write/read FSMs over a word-addressed RAM.
// Optional AXI_MEM_SLAVE_STALL_EN adds LFSR-driven ready/valid stalls.
module axi_mem_slave #(
  parameter int AXI_ID_WIDTH   = 6,
  parameter int AXI_LEN_WIDTH  = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int MEM_AWIDTH     = 9
) (
  input logic clk,
  input logic rst,
  axi_mem_slave_if.slave s_axi
);
  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam int BYTE_B = $clog2(STRB_W);
  localparam int DEPTH  = 1 << MEM_AWIDTH;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  logic [AXI_DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [1:0]                r_wstate;
  logic [MEM_AWIDTH-1:0]     r_widx;
  logic [AXI_LEN_WIDTH-1:0]  r_wcnt;
  logic [AXI_LEN_WIDTH-1:0]  r_awlen;
  logic                      r_werr;
  logic [AXI_ID_WIDTH-1:0]   r_bid;
  logic [1:0]                r_bresp;

  logic [0:0]                r_rstate;
  logic [MEM_AWIDTH-1:0]     r_ridx;
  logic [AXI_LEN_WIDTH-1:0]  r_rcnt;
  logic [AXI_LEN_WIDTH-1:0]  r_arlen;
  logic                      r_rvalid;
  logic                      r_rlast;
  logic [AXI_ID_WIDTH-1:0]   r_rid;
  logic [1:0]                r_rresp;
  logic [AXI_DATA_WIDTH-1:0] r_rdata;

  logic                      w_aw_go, w_w_go, w_ar_go, w_r_go;
  logic [MEM_AWIDTH-1:0]     w_awidx, w_aridx, w_ridx_nxt;
  logic [AXI_LEN_WIDTH-1:0]  w_rcnt_nxt;
  logic                      w_aw_hs, w_w_hs, w_ar_hs, w_r_hs;
  logic                      w_wlast_exp, w_beat_err;

`ifdef AXI_MEM_SLAVE_STALL_EN
  logic [7:0] r_lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_lfsr <= 8'hA5;
    else     r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end

  assign w_aw_go = r_lfsr[0];
  assign w_w_go  = r_lfsr[1];
  assign w_ar_go = r_lfsr[2];
  assign w_r_go  = r_lfsr[3];
`else
  assign w_aw_go = 1'b1;
  assign w_w_go  = 1'b1;
  assign w_ar_go = 1'b1;
  assign w_r_go  = 1'b1;
`endif

  // Upper address bits are dropped, so the word index wraps modulo DEPTH.
  assign w_awidx    = s_axi.axi_awaddr[MEM_AWIDTH+BYTE_B-1:BYTE_B];
  assign w_aridx    = s_axi.axi_araddr[MEM_AWIDTH+BYTE_B-1:BYTE_B];
  assign w_ridx_nxt = r_ridx + 1'b1;
  assign w_rcnt_nxt = r_rcnt + 1'b1;

  assign s_axi.axi_awready = (r_wstate == W_IDLE) & ~rst & w_aw_go;
  assign s_axi.axi_wready  = (r_wstate == W_DATA) & w_w_go;
  assign s_axi.axi_bvalid  = (r_wstate == W_RESP);
  assign s_axi.axi_bid     = r_bid;
  assign s_axi.axi_bresp   = r_bresp;

  assign s_axi.axi_arready = (r_rstate == R_IDLE) & ~rst & w_ar_go;
  assign s_axi.axi_rvalid  = r_rvalid;
  assign s_axi.axi_rdata   = r_rdata;
  assign s_axi.axi_rlast   = r_rlast;
  assign s_axi.axi_rid     = r_rid;
  assign s_axi.axi_rresp   = r_rresp;

  assign w_aw_hs     = s_axi.axi_awvalid & s_axi.axi_awready;
  assign w_w_hs      = s_axi.axi_wvalid & s_axi.axi_wready;
  assign w_ar_hs     = s_axi.axi_arvalid & s_axi.axi_arready;
  assign w_r_hs      = r_rvalid & s_axi.axi_rready;
  assign w_wlast_exp = (r_wcnt == r_awlen);
  assign w_beat_err  = s_axi.axi_wlast ^ w_wlast_exp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wstate <= W_IDLE;
      r_widx   <= '0;
      r_wcnt   <= '0;
      r_awlen  <= '0;
      r_werr   <= 1'b0;
      r_bid    <= '0;
      r_bresp  <= RESP_OKAY;
    end else begin
      case (r_wstate)
        W_IDLE: if (w_aw_hs) begin
          r_widx   <= w_awidx;
          r_awlen  <= s_axi.axi_awlen;
          r_bid    <= s_axi.axi_awid;
          r_werr   <= (s_axi.axi_awburst != BURST_INCR);
          r_wcnt   <= '0;
          r_wstate <= W_DATA;
        end
        W_DATA: if (w_w_hs) begin
          r_widx <= r_widx + 1'b1;
          r_werr <= r_werr | w_beat_err;
          if (w_wlast_exp) begin
            r_bresp  <= (r_werr | w_beat_err) ? RESP_SLVERR : RESP_OKAY;
            r_wstate <= W_RESP;
          end else begin
            r_wcnt <= r_wcnt + 1'b1;
          end
        end
        W_RESP: if (s_axi.axi_bready) r_wstate <= W_IDLE;
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // RAM contents survive reset; only the FSMs are cleared.
  always_ff @(posedge clk) begin
    if (w_w_hs) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi.axi_wstrb[b]) r_mem[r_widx][8*b +: 8] <= s_axi.axi_wdata[8*b +: 8];
      end
    end
  end

  // Read data is registered from the async RAM port, so a same-edge write is not seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rstate <= R_IDLE;
      r_ridx   <= '0;
      r_rcnt   <= '0;
      r_arlen  <= '0;
      r_rvalid <= 1'b0;
      r_rlast  <= 1'b0;
      r_rid    <= '0;
      r_rresp  <= RESP_OKAY;
      r_rdata  <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: if (w_ar_hs) begin
          r_rdata  <= r_mem[w_aridx];
          r_ridx   <= w_aridx;
          r_arlen  <= s_axi.axi_arlen;
          r_rcnt   <= '0;
          r_rlast  <= (s_axi.axi_arlen == '0);
          r_rid    <= s_axi.axi_arid;
          r_rresp  <= (s_axi.axi_arburst != BURST_INCR) ? RESP_SLVERR : RESP_OKAY;
          r_rvalid <= w_r_go;
          r_rstate <= R_DATA;
        end
        R_DATA: begin
          if (w_r_hs) begin
            if (r_rlast) begin
              r_rvalid <= 1'b0;
              r_rlast  <= 1'b0;
              r_rstate <= R_IDLE;
            end else begin
              r_ridx   <= w_ridx_nxt;
              r_rdata  <= r_mem[w_ridx_nxt];
              r_rcnt   <= w_rcnt_nxt;
              r_rlast  <= (w_rcnt_nxt == r_arlen);
              r_rvalid <= w_r_go;
            end
          end else if (!r_rvalid) begin
            r_rvalid <= w_r_go;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  logic w_unused_ok;
  assign w_unused_ok = ^{s_axi.axi_awsize, s_axi.axi_awlock, s_axi.axi_awcache,
                         s_axi.axi_awprot, s_axi.axi_awqos, s_axi.axi_wid,
                         s_axi.axi_arsize, s_axi.axi_arlock, s_axi.axi_arcache,
                         s_axi.axi_arprot, s_axi.axi_arqos,
                         s_axi.axi_awaddr[BYTE_B-1:0], s_axi.axi_araddr[BYTE_B-1:0],
                         s_axi.axi_awaddr[AXI_ADDR_WIDTH-1:MEM_AWIDTH+BYTE_B],
                         s_axi.axi_araddr[AXI_ADDR_WIDTH-1:MEM_AWIDTH+BYTE_B]};
endmodule

// File: tb/tb_axi_mem_slave.sv
// Randomized self-checking bench for axi_mem_slave against a word-array memory model.
module tb_axi_mem_slave;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_mem_slave_if #(.AXI_ID_WIDTH(6), .AXI_LEN_WIDTH(4), .AXI_ADDR_WIDTH(32),
                     .AXI_DATA_WIDTH(64)) bus ();

  axi_mem_slave #(.AXI_ID_WIDTH(6), .AXI_LEN_WIDTH(4), .AXI_ADDR_WIDTH(32),
                  .AXI_DATA_WIDTH(64), .MEM_AWIDTH(9)) dut (
    .clk(clk), .rst(rst), .s_axi(bus));

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] mdl [512];
  logic [63:0] wr_data [16];
  logic [7:0]  wr_strb [16];
  logic [1:0]  wr_bresp;
  logic [5:0]  wr_bid;
  logic [63:0] rd_data [16];
  logic        rd_last [16];
  logic [1:0]  rd_resp [16];
  logic [5:0]  rd_id   [16];
  int          rd_cyc  [16];
  int          rd_cnt;

  function automatic int word_of(input logic [31:0] addr, input int i);
    return (int'((addr >> 3) & 32'h1FF) + i) % 512;
  endfunction

  task automatic do_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input logic [5:0] id, input int early_last, input bit hold_b);
    int n;
    bus.axi_awid = id; bus.axi_awaddr = addr; bus.axi_awlen = len[3:0];
    bus.axi_awburst = burst; bus.axi_awsize = 3'd3; bus.axi_awvalid = 1'b1;
    n = 0;
    while (!bus.axi_awready && n < 100) begin @(posedge clk); #1; n++; end
    n_checks++;
    if (n >= 100) $display("FAIL aw_timeout: awready stayed %b, required 1", bus.axi_awready);
    else n_pass++;
    @(posedge clk); #1;
    bus.axi_awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      bus.axi_wdata = wr_data[i]; bus.axi_wstrb = wr_strb[i];
      bus.axi_wlast = (early_last >= 0) ? (i == early_last) : (i == len);
      bus.axi_wid = 6'($urandom); bus.axi_wvalid = 1'b1;
      n = 0;
      while (!bus.axi_wready && n < 100) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
    end
    bus.axi_wvalid = 1'b0; bus.axi_wlast = 1'b0;
    bus.axi_bready = !hold_b;
    n = 0;
    while (!bus.axi_bvalid && n < 100) begin @(posedge clk); #1; n++; end
    n_checks++;
    if (n >= 100) $display("FAIL b_timeout: bvalid stayed %b, required 1", bus.axi_bvalid);
    else n_pass++;
    wr_bid = bus.axi_bid; wr_bresp = bus.axi_bresp;
    if (hold_b) begin
      for (int k = 0; k < 10; k++) begin
        @(posedge clk); #1;
        n_checks++;
        if ({bus.axi_bvalid, bus.axi_awready, bus.axi_bid, bus.axi_bresp} !== {2'b10, wr_bid, wr_bresp})
          $display("FAIL b_hold cyc%0d: bvalid=%b awready=%b bid=%h bresp=%b, required 1 0 %h %b",
                   k, bus.axi_bvalid, bus.axi_awready, bus.axi_bid, bus.axi_bresp, wr_bid, wr_bresp);
        else n_pass++;
      end
      bus.axi_bready = 1'b1;
    end
    @(posedge clk); #1;
    bus.axi_bready = 1'b0;
    n_checks++;
    if ({bus.axi_bvalid, bus.axi_awready} !== 2'b01)
      $display("FAIL b_done: bvalid=%b awready=%b, required 0 1", bus.axi_bvalid, bus.axi_awready);
    else n_pass++;
    for (int i = 0; i <= len; i++)
      for (int b = 0; b < 8; b++)
        if (wr_strb[i][b]) mdl[word_of(addr, i)][8*b +: 8] = wr_data[i][8*b +: 8];
  endtask

  // mode 0: rready always 1; mode 1: random rready; mode 2: rready 1-0-1-0...
  task automatic do_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                         input logic [5:0] id, input int mode);
    int n, cyc;
    bit stalled;
    logic [72:0] held;
    bus.axi_arid = id; bus.axi_araddr = addr; bus.axi_arlen = len[3:0];
    bus.axi_arburst = burst; bus.axi_arsize = 3'd3; bus.axi_arvalid = 1'b1;
    n = 0;
    while (!bus.axi_arready && n < 100) begin @(posedge clk); #1; n++; end
    n_checks++;
    if (n >= 100) $display("FAIL ar_timeout: arready stayed %b, required 1", bus.axi_arready);
    else n_pass++;
    @(posedge clk); #1;
    bus.axi_arvalid = 1'b0;
    rd_cnt = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (rd_cnt <= len && cyc < 200) begin
      case (mode)
        0:       bus.axi_rready = 1'b1;
        1:       bus.axi_rready = 1'($urandom_range(0, 1));
        default: bus.axi_rready = (cyc % 2 == 0);
      endcase
      if (stalled) begin
        n_checks++;
        if ({bus.axi_rvalid, bus.axi_rdata, bus.axi_rlast, bus.axi_rresp, bus.axi_rid} !== {1'b1, held})
          $display("FAIL r_stable beat%0d: got %h, required %h", rd_cnt,
                   {bus.axi_rdata, bus.axi_rlast, bus.axi_rresp, bus.axi_rid}, held);
        else n_pass++;
      end
      if (bus.axi_rvalid && bus.axi_rready) begin
        rd_data[rd_cnt] = bus.axi_rdata; rd_last[rd_cnt] = bus.axi_rlast;
        rd_resp[rd_cnt] = bus.axi_rresp; rd_id[rd_cnt] = bus.axi_rid;
        rd_cyc[rd_cnt] = cyc; rd_cnt++;
        stalled = 1'b0;
      end else if (bus.axi_rvalid) begin
        held = {bus.axi_rdata, bus.axi_rlast, bus.axi_rresp, bus.axi_rid};
        stalled = 1'b1;
      end else begin
        stalled = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.axi_rready = 1'b0;
    n_checks++;
    if (rd_cnt != len + 1 || bus.axi_rvalid !== 1'b0)
      $display("FAIL read_end: beats=%0d rvalid=%b, required %0d 0", rd_cnt, bus.axi_rvalid, len + 1);
    else n_pass++;
  endtask

  task automatic check_read(input string name, input logic [31:0] addr, input int len,
                            input logic [1:0] resp, input logic [5:0] id);
    for (int i = 0; i <= len && i < rd_cnt; i++) begin
      n_checks++;
      if ({rd_data[i], rd_last[i], rd_resp[i], rd_id[i]} !== {mdl[word_of(addr, i)], (i == len), resp, id})
        $display("FAIL %s beat%0d: data=%h last=%b resp=%b id=%h, required %h %b %b %h", name, i,
                 rd_data[i], rd_last[i], rd_resp[i], rd_id[i], mdl[word_of(addr, i)], (i == len), resp, id);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.axi_awready, bus.axi_arready, bus.axi_bvalid, bus.axi_rvalid, bus.axi_rlast,
         bus.axi_bresp, bus.axi_rresp, bus.axi_bid, bus.axi_rid, bus.axi_rdata} !== '0)
      $display("FAIL reset_state: awr=%b arr=%b bv=%b rv=%b rl=%b rdata=%h, required all 0",
               bus.axi_awready, bus.axi_arready, bus.axi_bvalid, bus.axi_rvalid, bus.axi_rlast, bus.axi_rdata);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.axi_awready, bus.axi_arready} !== 2'b11)
      $display("FAIL reset_release: awready=%b arready=%b, required 1 1", bus.axi_awready, bus.axi_arready);
    else n_pass++;
  endtask

  task automatic test_fill();
    for (int blk = 0; blk < 32; blk++) begin
      for (int i = 0; i < 16; i++) begin wr_data[i] = {$urandom, $urandom}; wr_strb[i] = 8'hFF; end
      do_write(32'(blk * 128), 15, 2'b01, 6'(blk), -1, 1'b0);
      n_checks++;
      if ({wr_bresp, wr_bid} !== {2'b00, 6'(blk)})
        $display("FAIL fill_b blk%0d: bresp=%b bid=%h, required 00 %h", blk, wr_bresp, wr_bid, 6'(blk));
      else n_pass++;
    end
  endtask

  task automatic test_single();
    logic [5:0] id;
    id = 6'($urandom);
    wr_data[0] = 64'h1122334455667788; wr_strb[0] = 8'hFF;
    do_write(32'h08, 0, 2'b01, id, -1, 1'b0);
    n_checks++;
    if ({wr_bresp, wr_bid} !== {2'b00, id})
      $display("FAIL single_b: bresp=%b bid=%h, required 00 %h", wr_bresp, wr_bid, id);
    else n_pass++;
    do_read(32'h08, 0, 2'b01, ~id, 0);
    n_checks++;
    if ({rd_data[0], rd_last[0], rd_resp[0]} !== {64'h1122334455667788, 1'b1, 2'b00})
      $display("FAIL single_r: data=%h last=%b resp=%b, required 1122334455667788 1 00",
               rd_data[0], rd_last[0], rd_resp[0]);
    else n_pass++;
  endtask

  task automatic test_burst();
    logic [63:0] base;
    base = {$urandom, $urandom};
    for (int i = 0; i < 16; i++) begin wr_data[i] = base + 64'(i); wr_strb[i] = 8'hFF; end
    do_write(32'h0, 15, 2'b01, 6'h15, -1, 1'b0);
    do_read(32'h0, 15, 2'b01, 6'h2A, 0);
    check_read("burst", 32'h0, 15, 2'b00, 6'h2A);
    for (int i = 0; i < rd_cnt; i++) begin
      n_checks++;
      if (rd_data[i] !== base + 64'(i) || rd_cyc[i] != i)
        $display("FAIL burst_order beat%0d: data=%h cycle=%0d, required %h %0d",
                 i, rd_data[i], rd_cyc[i], base + 64'(i), i);
      else n_pass++;
    end
  endtask

  task automatic test_strobe_wrap();
    for (int i = 0; i < 2; i++) begin wr_data[i] = 64'h0; wr_strb[i] = 8'hFF; end
    do_write(32'hFF8, 1, 2'b01, 6'h01, -1, 1'b0);
    for (int i = 0; i < 2; i++) begin wr_data[i] = '1; wr_strb[i] = 8'h0F; end
    do_write(32'hFF8, 1, 2'b01, 6'h02, -1, 1'b0);
    n_checks++;
    if (wr_bresp !== 2'b00) $display("FAIL strobe_b: bresp=%b, required 00", wr_bresp);
    else n_pass++;
    do_read(32'hFF8, 1, 2'b01, 6'h03, 0);
    n_checks++;
    if ({rd_data[0], rd_data[1]} !== {64'h00000000FFFFFFFF, 64'h00000000FFFFFFFF})
      $display("FAIL strobe_wrap: w511=%h w0=%h, required 00000000ffffffff both", rd_data[0], rd_data[1]);
    else n_pass++;
  endtask

  task automatic test_protocol_err();
    for (int i = 0; i < 4; i++) begin wr_data[i] = {$urandom, $urandom}; wr_strb[i] = 8'hFF; end
    do_write(32'h200, 3, 2'b01, 6'h11, 1, 1'b0);
    n_checks++;
    if (wr_bresp !== 2'b10) $display("FAIL wlast_err: bresp=%b, required 10", wr_bresp);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin wr_data[i] = {$urandom, $urandom}; wr_strb[i] = 8'hFF; end
    do_write(32'h300, 3, 2'b00, 6'h12, -1, 1'b0);
    n_checks++;
    if (wr_bresp !== 2'b10) $display("FAIL awburst_err: bresp=%b, required 10", wr_bresp);
    else n_pass++;
    do_read(32'h200, 3, 2'b00, 6'h13, 0);
    check_read("arburst_err", 32'h200, 3, 2'b10, 6'h13);
  endtask

  task automatic test_backpressure();
    do_read(32'h300, 3, 2'b01, 6'h21, 2);
    check_read("rready_toggle", 32'h300, 3, 2'b00, 6'h21);
    for (int i = 0; i < 3; i++) begin wr_data[i] = {$urandom, $urandom}; wr_strb[i] = 8'($urandom); end
    do_write(32'h400, 2, 2'b01, 6'h22, -1, 1'b1);
    do_read(32'h400, 2, 2'b01, 6'h23, 1);
    check_read("bready_hold", 32'h400, 2, 2'b00, 6'h23);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin wr_data[i] = {$urandom, $urandom}; wr_strb[i] = 8'hFF; end
    fork
      do_write(32'h320, 7, 2'b01, 6'h31, -1, 1'b0);
      do_read(32'h0, 15, 2'b01, 6'h32, 0);
    join
    check_read("concurrent_r", 32'h0, 15, 2'b00, 6'h32);
    for (int i = 0; i < rd_cnt; i++) begin
      n_checks++;
      if (rd_cyc[i] != i) $display("FAIL concurrent_rate beat%0d: cycle=%0d, required %0d", i, rd_cyc[i], i);
      else n_pass++;
    end
    do_read(32'h320, 7, 2'b01, 6'h33, 1);
    check_read("concurrent_w", 32'h320, 7, 2'b00, 6'h33);
  endtask

  task automatic test_random();
    logic [31:0] addr;
    int len;
    logic [5:0] id;
    for (int t = 0; t < 8; t++) begin
      addr = $urandom & 32'hFFFF_FFF8;
      len = $urandom_range(0, 15);
      id = 6'($urandom);
      for (int i = 0; i <= len; i++) begin wr_data[i] = {$urandom, $urandom}; wr_strb[i] = 8'($urandom); end
      do_write(addr, len, 2'b01, id, -1, 1'b0);
      n_checks++;
      if ({wr_bresp, wr_bid} !== {2'b00, id})
        $display("FAIL random_b t%0d: bresp=%b bid=%h, required 00 %h", t, wr_bresp, wr_bid, id);
      else n_pass++;
      addr = addr ^ ($urandom & 32'hFFFF_F000);
      do_read(addr, len, 2'b01, ~id, 1);
      check_read("random_r", addr, len, 2'b00, ~id);
    end
  endtask

  task automatic test_reset_mid_read();
    int n;
    bus.axi_arid = 6'h3C; bus.axi_araddr = 32'h0; bus.axi_arlen = 4'd15;
    bus.axi_arburst = 2'b01; bus.axi_arvalid = 1'b1;
    n = 0;
    while (!bus.axi_arready && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.axi_arvalid = 1'b0; bus.axi_rready = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.axi_rvalid, bus.axi_arready, bus.axi_awready} !== 3'b000)
      $display("FAIL reset_mid: rvalid=%b arready=%b awready=%b, required 0 0 0",
               bus.axi_rvalid, bus.axi_arready, bus.axi_awready);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0; bus.axi_rready = 1'b0;
    #1;
    n_checks++;
    if ({bus.axi_arready, bus.axi_awready, bus.axi_rvalid, bus.axi_bvalid} !== 4'b1100)
      $display("FAIL reset_mid_release: arready=%b awready=%b rvalid=%b bvalid=%b, required 1 1 0 0",
               bus.axi_arready, bus.axi_awready, bus.axi_rvalid, bus.axi_bvalid);
    else n_pass++;
    do_read(32'h0, 15, 2'b01, 6'h3D, 0);
    check_read("mem_intact", 32'h0, 15, 2'b00, 6'h3D);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.axi_awid = '0; bus.axi_awaddr = '0; bus.axi_awlen = '0; bus.axi_awsize = 3'd3;
    bus.axi_awburst = 2'b01; bus.axi_awlock = '0; bus.axi_awcache = '0; bus.axi_awprot = '0;
    bus.axi_awqos = '0; bus.axi_awvalid = 1'b0;
    bus.axi_wid = '0; bus.axi_wdata = '0; bus.axi_wstrb = '0; bus.axi_wlast = 1'b0; bus.axi_wvalid = 1'b0;
    bus.axi_bready = 1'b0;
    bus.axi_arid = '0; bus.axi_araddr = '0; bus.axi_arlen = '0; bus.axi_arsize = 3'd3;
    bus.axi_arburst = 2'b01; bus.axi_arlock = '0; bus.axi_arcache = '0; bus.axi_arprot = '0;
    bus.axi_arqos = '0; bus.axi_arvalid = 1'b0;
    bus.axi_rready = 1'b0;
    test_reset();
    test_fill();
    test_single();
    test_burst();
    test_strobe_wrap();
    test_protocol_err();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/axi_mem_slave.md
AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

Interface
REQ-001 SHALL have parameter AXI_ID_WIDTH, default 6, ID width of all channels.
REQ-002 SHALL have parameter AXI_LEN_WIDTH, default 4, burst length field width (AXI3).
REQ-003 SHALL have parameter AXI_ADDR_WIDTH, default 32, byte address width.
REQ-004 SHALL have parameter AXI_DATA_WIDTH, default 64, data width; strobe width is AXI_DATA_WIDTH/8.
REQ-005 SHALL have parameter MEM_AWIDTH, default 9, log2 of memory depth in data words.
REQ-006 SHALL have ports (clock and reset first):
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- AW channel: axi_awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awqos/awvalid in, axi_awready out.
- W channel: axi_wid/wdata/wstrb/wlast/wvalid in, axi_wready out.
- B channel: axi_bid out (AXI_ID_WIDTH), axi_bresp out (2), axi_bvalid out, axi_bready in.
- AR channel: axi_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arqos/arvalid in, axi_arready out.
- R channel: axi_rid, axi_rdata, axi_rresp (2), axi_rlast, axi_rvalid out; axi_rready in.
- Widths of all channel fields match the AXI master of the HP port.
REQ-007 SHALL ignore awsize/arsize, lock, cache, prot, qos and wid; every beat is a full AXI_DATA_WIDTH word.

Function
REQ-008 SHALL implement a memory of 2**MEM_AWIDTH words with asynchronous read and synchronous write.
REQ-009 SHALL form the word index as addr[MEM_AWIDTH+B-1:B], B = log2(AXI_DATA_WIDTH/8); higher address bits are ignored, so the index wraps modulo depth.
REQ-010 SHALL run the write and read paths as independent state machines that may be active in the same cycle.
REQ-011 Write FSM SHALL have states W_IDLE (awready=1), W_DATA (wready=1) and W_RESP (bvalid=1), with transitions W_IDLE->W_DATA on awvalid&awready, W_DATA->W_RESP on the accepted beat whose count equals awlen, and W_RESP->W_IDLE on bready.
REQ-012 SHALL write each accepted W beat byte-wise under wstrb at the current index, then increment the index by 1 (wrapping).
REQ-013 SHALL latch awid and return it on bid.
REQ-014 SHALL set bresp=2'b10 (SLVERR) if wlast on any beat differs from (beat count==awlen), or if awburst!=2'b01; otherwise bresp=2'b00. Data is written in all cases.
REQ-015 Read FSM SHALL have states R_IDLE (arready=1) and R_DATA (rvalid=1), with transitions R_IDLE->R_DATA on the AR handshake and R_DATA->R_IDLE on the beat accepted with rlast.
REQ-016 SHALL register rdata: load mem[araddr index] at the AR handshake, then load mem[index+1] on each accepted non-last beat; rvalid rises the cycle after AR handshake; throughput is 1 beat/cycle while rready=1.
REQ-017 SHALL assert rlast on beat arlen, drive rid=latched arid, and drive rresp=SLVERR for the whole burst when arburst!=2'b01, else OKAY.
REQ-018 SHALL hold rdata/rlast/rid/rresp stable while rvalid&~rready, and hold bid/bresp stable while bvalid&~bready.
REQ-019 On a same-cycle write and read-load of the same word, SHALL return pre-write data.
REQ-020 SHALL accept a new AW in the first cycle after B completes; bvalid never waits on the read path.

Reset
REQ-021 rst SHALL asynchronously force W_IDLE and R_IDLE, bvalid=0, rvalid=0, rlast=0, bresp=0, rresp=0, bid=0, rid=0, rdata=0, and beat counters=0.
REQ-022 awready and arready SHALL be 0 while rst=1 and 1 in the first cycle after release.
REQ-023 Memory contents SHALL NOT be reset; a reset mid-burst aborts the burst with no B or further R beats.

Configuration
REQ-024 Macro AXI_MEM_SLAVE_STALL_EN: when defined, an internal 8-bit LFSR (seed 8'hA5, reset to seed) SHALL gate awready, wready, arready and R-beat issue, asserting each only when its dedicated LFSR bit is 1 and keeping all valid/data stability rules. When undefined, there is no LFSR and timing is exactly as in REQ-011 and REQ-016.

Verification
REQ-025 Single write: AW addr 0x08 len 0; W data 0x1122334455667788, wstrb 0xFF, wlast=1 -> one B with bresp 0 and bid equal to awid; a subsequent read of 0x08 returns that data with rlast=1.
REQ-026 Burst: AW addr 0x0 len 15 with incrementing data, then AR addr 0x0 len 15 with rready=1 -> 16 consecutive R beats, one per cycle, in order; rlast only on beat 15.
REQ-027 Strobe and wrap: write 0xFFFF_FFFF_FFFF_FFFF with wstrb 0x0F to word 511 (addr 0xFF8), len 1 -> word 511 = 0x0000_0000_FFFF_FFFF, word 0 updated; bresp 0.
REQ-028 Protocol error: len 3 with wlast asserted on beat 1 -> bresp=2'b10 after beat 3; awburst=2'b00 read -> all rresp=2'b10.
REQ-029 Backpressure: rready toggled 1-0-1 during a len-3 read -> no beat is lost or duplicated and rdata is stable while stalled; with bready held 0 for 10 cycles, bvalid stays 1 and awready stays 0.
REQ-030 Async reset asserted mid read burst -> rvalid=0 immediately (same cycle), arready=1 the cycle after release, memory intact.
